// File: rtl/tft_ili9341_pkg.sv
// Shared constants and types for the ILI9341 SPI receive path.
// Command codes, decoder states and coordinate width.
package tft_ili9341_pkg;

    localparam int COORD_W = 9;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_PASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CASET_P,
        ST_PASET_P,
        ST_RAMWR_HI,
        ST_RAMWR_LO
    } dec_state_e;

    typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/tft_ili9341_spi_deser.sv
// Oversampling front end: synchronizes the SPI pins, detects SCK rising
// edges and shifts 9-bit {dc, byte} words out, flagging truncated bytes.
module tft_ili9341_spi_deser #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tft_sck,
    input  logic       tft_sdi,
    input  logic       tft_dc,
    input  logic       tft_cs,
    output logic       rxValid,
    output logic [8:0] rxData,
    output logic       frameErr
);

    logic [SYNC_STAGES-1:0] sck_sq;
    logic [SYNC_STAGES-1:0] sdi_sq;
    logic [SYNC_STAGES-1:0] dc_sq;
    logic [SYNC_STAGES-1:0] cs_sq;

    logic       sck_prev_q;
    logic       cs_prev_q;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic       dc_q, dc_d;
    logic       full_q, full_d;
    logic       rxv_q, rxv_d;
    logic [8:0] rxd_q, rxd_d;
    logic       ferr_q, ferr_d;

    logic sck_s, sdi_s, dc_s, cs_s;
    logic sck_rise, cs_rise;

    assign sck_s    = sck_sq[SYNC_STAGES-1];
    assign sdi_s    = sdi_sq[SYNC_STAGES-1];
    assign dc_s     = dc_sq[SYNC_STAGES-1];
    assign cs_s     = cs_sq[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign cs_rise  = cs_s & ~cs_prev_q;

    // The 8th edge wraps the counter and arms full_q; the word is
    // presented one cycle later so rxValid and a CS rise never collide.
    always_comb begin
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        dc_d    = dc_q;
        full_d  = 1'b0;
        rxv_d   = full_q;
        rxd_d   = full_q ? {dc_q, shreg_q} : rxd_q;
        ferr_d  = 1'b0;
        if (sck_rise && !cs_s) begin
            shreg_d = {shreg_q[6:0], sdi_s};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                dc_d   = dc_s;
                full_d = 1'b1;
            end
        end
        if (cs_rise && cnt_q != 3'd0) begin
            cnt_d   = 3'd0;
            shreg_d = 8'd0;
            ferr_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sq     <= '0;
            sdi_sq     <= '0;
            dc_sq      <= '0;
            cs_sq      <= '1;
            sck_prev_q <= 1'b0;
            cs_prev_q  <= 1'b1;
            cnt_q      <= 3'd0;
            shreg_q    <= 8'd0;
            dc_q       <= 1'b0;
            full_q     <= 1'b0;
            rxv_q      <= 1'b0;
            rxd_q      <= 9'd0;
            ferr_q     <= 1'b0;
        end else begin
            sck_sq     <= {sck_sq[SYNC_STAGES-2:0], tft_sck};
            sdi_sq     <= {sdi_sq[SYNC_STAGES-2:0], tft_sdi};
            dc_sq      <= {dc_sq[SYNC_STAGES-2:0], tft_dc};
            cs_sq      <= {cs_sq[SYNC_STAGES-2:0], tft_cs};
            sck_prev_q <= sck_s;
            cs_prev_q  <= cs_s;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            dc_q       <= dc_d;
            full_q     <= full_d;
            rxv_q      <= rxv_d;
            rxd_q      <= rxd_d;
            ferr_q     <= ferr_d;
        end
    end

    assign rxValid  = rxv_q;
    assign rxData   = rxd_q;
    assign frameErr = ferr_q;

endmodule

// File: rtl/tft_ili9341_spi_rx.sv
// ILI9341 SPI receiver: decodes CASET/PASET/RAMWR into an addressed
// RGB565 pixel stream for on-chip display emulation.
module tft_ili9341_spi_rx
    import tft_ili9341_pkg::*;
#(
    parameter int WIDTH       = 240,
    parameter int HEIGHT      = 320,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tft_sck,
    input  logic        tft_sdi,
    input  logic        tft_dc,
    input  logic        tft_cs,
    output logic        rxValid,
    output logic [8:0]  rxData,
    output logic        cmdValid,
    output logic [7:0]  cmdCode,
    output logic        pixValid,
    output logic [8:0]  pixX,
    output logic [8:0]  pixY,
    output logic [15:0] pixColor,
    output logic        frameErr
);

    localparam logic [15:0] W16   = 16'(WIDTH);
    localparam logic [15:0] H16   = 16'(HEIGHT);
    localparam coord_t      XMAX  = coord_t'(WIDTH - 1);
    localparam coord_t      YMAX  = coord_t'(HEIGHT - 1);

    tft_ili9341_spi_deser #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_deser (
        .clk      (clk),
        .rst      (rst),
        .tft_sck  (tft_sck),
        .tft_sdi  (tft_sdi),
        .tft_dc   (tft_dc),
        .tft_cs   (tft_cs),
        .rxValid  (rxValid),
        .rxData   (rxData),
        .frameErr (frameErr)
    );

    dec_state_e  state_q;
    logic [1:0]  idx_q;
    logic [23:0] par_q;
    logic [7:0]  hi_q;
    coord_t      xs_q, xe_q, ys_q, ye_q;
    coord_t      x_q, y_q;

    logic [31:0] par_full;
    logic [15:0] p_start, p_end;
    logic [7:0]  rx_byte;

    assign rx_byte  = rxData[7:0];
    assign par_full = {par_q, rx_byte};
    assign p_start  = par_full[31:16];
    assign p_end    = par_full[15:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= 2'd0;
            par_q    <= 24'd0;
            hi_q     <= 8'd0;
            xs_q     <= '0;
            xe_q     <= XMAX;
            ys_q     <= '0;
            ye_q     <= YMAX;
            x_q      <= '0;
            y_q      <= '0;
            cmdValid <= 1'b0;
            cmdCode  <= 8'd0;
            pixValid <= 1'b0;
            pixX     <= 9'd0;
            pixY     <= 9'd0;
            pixColor <= 16'd0;
        end else begin
            cmdValid <= 1'b0;
            pixValid <= 1'b0;
            if (rxValid && !rxData[8]) begin
                // Any command aborts whatever parameter/pixel was in flight.
                cmdValid <= 1'b1;
                cmdCode  <= rx_byte;
                idx_q    <= 2'd0;
                unique case (rx_byte)
                    CMD_CASET: state_q <= ST_CASET_P;
                    CMD_PASET: state_q <= ST_PASET_P;
                    CMD_RAMWR: begin
                        x_q     <= xs_q;
                        y_q     <= ys_q;
                        state_q <= ST_RAMWR_HI;
                    end
                    default:   state_q <= ST_IDLE;
                endcase
            end else if (rxValid) begin
                unique case (state_q)
                    ST_CASET_P, ST_PASET_P: begin
                        par_q <= {par_q[15:0], rx_byte};
                        idx_q <= idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            state_q <= ST_IDLE;
                            if (state_q == ST_CASET_P) begin
                                if (p_start <= p_end && p_end < W16) begin
                                    xs_q <= p_start[8:0];
                                    xe_q <= p_end[8:0];
                                end
                            end else if (p_start <= p_end && p_end < H16) begin
                                ys_q <= p_start[8:0];
                                ye_q <= p_end[8:0];
                            end
                        end
                    end
                    ST_RAMWR_HI: begin
                        hi_q    <= rx_byte;
                        state_q <= ST_RAMWR_LO;
                    end
                    ST_RAMWR_LO: begin
                        pixValid <= 1'b1;
                        pixX     <= x_q;
                        pixY     <= y_q;
                        pixColor <= {hi_q, rx_byte};
                        state_q  <= ST_RAMWR_HI;
                        if (x_q == xe_q) begin
                            x_q <= xs_q;
                            y_q <= (y_q == ye_q) ? ys_q : y_q + 9'd1;
                        end else begin
                            x_q <= x_q + 9'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tft_ili9341_spi_rx.sv
// Directed bench for tft_ili9341_spi_rx: bit-bangs SPI at clk/8 and
// checks decoded commands, pixels, framing errors and reset.
module tb_tft_ili9341_spi_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        tft_sck, tft_sdi, tft_dc, tft_cs;
    logic        rxValid;
    logic [8:0]  rxData;
    logic        cmdValid;
    logic [7:0]  cmdCode;
    logic        pixValid;
    logic [8:0]  pixX, pixY;
    logic [15:0] pixColor;
    logic        frameErr;

    int checks = 0;
    int failures = 0;

    logic [33:0] pix_q[$];
    logic [8:0]  rx_q[$];
    int          ferr_cnt = 0;
    int          cmd_cnt = 0;

    always #5 clk = ~clk;

    tft_ili9341_spi_rx dut (
        .clk      (clk),
        .rst      (rst),
        .tft_sck  (tft_sck),
        .tft_sdi  (tft_sdi),
        .tft_dc   (tft_dc),
        .tft_cs   (tft_cs),
        .rxValid  (rxValid),
        .rxData   (rxData),
        .cmdValid (cmdValid),
        .cmdCode  (cmdCode),
        .pixValid (pixValid),
        .pixX     (pixX),
        .pixY     (pixY),
        .pixColor (pixColor),
        .frameErr (frameErr)
    );

    always @(negedge clk) begin
        if (pixValid) pix_q.push_back({pixX, pixY, pixColor});
        if (rxValid) rx_q.push_back(rxData);
        if (frameErr) ferr_cnt++;
        if (cmdValid) cmd_cnt++;
    end

    task automatic clear_log();
        pix_q.delete();
        rx_q.delete();
        ferr_cnt = 0;
        cmd_cnt = 0;
    endtask

    task automatic send_bits(input logic dc, input logic [7:0] b, input int n);
        logic [7:0] v;
        v = b;
        tft_dc = dc;
        for (int i = 0; i < n; i++) begin
            tft_sck = 1'b0;
            tft_sdi = v[7-i];
            repeat (4) @(posedge clk);
            tft_sck = 1'b1;
            repeat (4) @(posedge clk);
        end
    endtask

    task automatic send(input logic dc, input logic [7:0] b);
        send_bits(dc, b, 8);
    endtask

    task automatic cs_low();
        tft_cs = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic cs_high();
        tft_sck = 1'b0;
        repeat (2) @(posedge clk);
        tft_cs = 1'b1;
        repeat (12) @(posedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tft_sck = 1'b0;
        tft_cs = 1'b1;
        repeat (4) @(posedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic check_pix(input string name, input int k,
                             input logic [8:0] x, input logic [8:0] y,
                             input logic [15:0] c);
        logic [33:0] got, exp;
        exp = {x, y, c};
        got = (k < pix_q.size()) ? pix_q[k] : 34'h3_FFFF_FFFF;
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s pix%0d: got x=%0d y=%0d c=%h want x=%0d y=%0d c=%h",
                     name, k, got[33:25], got[24:16], got[15:0], x, y, c);
        end
    endtask

    task automatic test_reset();
        tft_sdi = 1'b0;
        tft_dc = 1'b0;
        apply_reset();
        @(negedge clk);
        checks++;
        if ({rxValid, rxData, cmdValid, cmdCode, pixValid, pixX, pixY,
             pixColor, frameErr} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got nonzero rxData=%h cmdCode=%h pix=%0d,%0d,%h want 0",
                     rxData, cmdCode, pixX, pixY, pixColor);
        end
    endtask

    task automatic test_single_pixel();
        clear_log();
        cs_low();
        send(1'b0, 8'h2C);
        send(1'b1, 8'hF8);
        send(1'b1, 8'h00);
        cs_high();
        checks++;
        if (cmd_cnt !== 1 || cmdCode !== 8'h2C) begin
            failures++;
            $display("FAIL single_cmd: got cnt=%0d code=%h want 1 2c", cmd_cnt, cmdCode);
        end
        checks++;
        if (rx_q.size() !== 3 || rx_q[0] !== 9'h02C || rx_q[1] !== 9'h1F8) begin
            failures++;
            $display("FAIL single_rx: got n=%0d want 3 words 02c,1f8,100", rx_q.size());
        end
        checks++;
        if (pix_q.size() !== 1) begin
            failures++;
            $display("FAIL single_npix: got %0d want 1", pix_q.size());
        end
        check_pix("single", 0, 9'd0, 9'd0, 16'hF800);
    endtask

    task automatic test_window();
        logic [8:0] ex[5] = '{9'd10, 9'd11, 9'd10, 9'd11, 9'd10};
        logic [8:0] ey[5] = '{9'd5, 9'd5, 9'd6, 9'd6, 9'd5};
        clear_log();
        cs_low();
        send(1'b0, 8'h2A);
        send(1'b1, 8'h00); send(1'b1, 8'h0A);
        send(1'b1, 8'h00); send(1'b1, 8'h0B);
        send(1'b0, 8'h2B);
        send(1'b1, 8'h00); send(1'b1, 8'h05);
        send(1'b1, 8'h00); send(1'b1, 8'h06);
        send(1'b0, 8'h2C);
        for (int i = 0; i < 5; i++) begin
            send(1'b1, 8'h10);
            send(1'b1, 8'(i));
        end
        cs_high();
        checks++;
        if (pix_q.size() !== 5) begin
            failures++;
            $display("FAIL window_npix: got %0d want 5", pix_q.size());
        end
        for (int i = 0; i < 5; i++)
            check_pix("window", i, ex[i], ey[i], 16'h1000 + 16'(i));
    endtask

    task automatic test_bad_caset();
        apply_reset();
        clear_log();
        cs_low();
        send(1'b0, 8'h2A);
        send(1'b1, 8'h00); send(1'b1, 8'h20);
        send(1'b1, 8'h00); send(1'b1, 8'h10);
        send(1'b0, 8'h2A);
        send(1'b1, 8'h00); send(1'b1, 8'h05);
        send(1'b1, 8'h00); send(1'b1, 8'hF0);
        send(1'b0, 8'h2C);
        send(1'b1, 8'h55); send(1'b1, 8'hAA);
        cs_high();
        checks++;
        if (pix_q.size() !== 1) begin
            failures++;
            $display("FAIL badcaset_npix: got %0d want 1", pix_q.size());
        end
        check_pix("badcaset", 0, 9'd0, 9'd0, 16'h55AA);
    endtask

    task automatic test_frame_err();
        clear_log();
        cs_low();
        send_bits(1'b1, 8'hFF, 5);
        cs_high();
        cs_low();
        send(1'b0, 8'h2C);
        cs_high();
        checks++;
        if (ferr_cnt !== 1) begin
            failures++;
            $display("FAIL frameerr_cnt: got %0d want 1", ferr_cnt);
        end
        checks++;
        if (rx_q.size() !== 1 || rx_q[0] !== 9'h02C) begin
            failures++;
            $display("FAIL frameerr_rx: got n=%0d first=%h want 1 02c",
                     rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 9'h1FF);
        end
    endtask

    task automatic test_abort();
        clear_log();
        cs_low();
        send(1'b0, 8'h2C);
        send(1'b1, 8'h12);
        send(1'b0, 8'h00);
        send(1'b1, 8'h34);
        send(1'b1, 8'h56);
        cs_high();
        checks++;
        if (pix_q.size() !== 0) begin
            failures++;
            $display("FAIL abort_npix: got %0d want 0", pix_q.size());
        end
        checks++;
        if (cmdCode !== 8'h00 || cmd_cnt !== 2) begin
            failures++;
            $display("FAIL abort_cmd: got code=%h cnt=%0d want 00 2", cmdCode, cmd_cnt);
        end
        checks++;
        if (rx_q.size() !== 5) begin
            failures++;
            $display("FAIL abort_rx: got %0d words want 5", rx_q.size());
        end
    endtask

    task automatic test_reset_mid();
        clear_log();
        cs_low();
        send(1'b0, 8'h2C);
        send(1'b1, 8'h11);
        repeat (6) @(posedge clk);
        rst = 1'b1;
        tft_sck = 1'b0;
        tft_cs = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({rxValid, rxData, cmdValid, cmdCode, pixValid, pixX, pixY,
             pixColor, frameErr} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs: got cmdCode=%h rxData=%h want 0",
                     cmdCode, rxData);
        end
        @(posedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        clear_log();
        cs_low();
        send(1'b0, 8'h2C);
        send(1'b1, 8'hAB);
        send(1'b1, 8'hCD);
        cs_high();
        checks++;
        if (pix_q.size() !== 1) begin
            failures++;
            $display("FAIL midreset_npix: got %0d want 1", pix_q.size());
        end
        check_pix("midreset", 0, 9'd0, 9'd0, 16'hABCD);
    endtask

    initial begin
        rst = 1'b1;
        tft_sck = 1'b0;
        tft_sdi = 1'b0;
        tft_dc = 1'b0;
        tft_cs = 1'b1;
        test_reset();
        test_single_pixel();
        test_window();
        test_bad_caset();
        test_frame_err();
        test_abort();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
